// File: rtl/alu_pkg.sv
// alu_pkg: shared datapath width, flag bit positions and result-stage state encoding.
package alu_pkg;
  localparam int WIDTH = 16;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;
endpackage

// File: rtl/alu_flag_gen.sv
// alu_flag_gen: Z/N/C/V from adder outputs; ALU_RESULT_SATURATE_EN clamps overflowed results.
module alu_flag_gen #(
  parameter int W = alu_pkg::WIDTH
) (
  input  logic [W-1:0] sum_i,
  input  logic         carry_i,
  input  logic         a_msb_i,
  input  logic         b_msb_i,
  output logic [W-1:0] result_o,
  output logic [3:0]   flags_o
);
  import alu_pkg::*;
  logic v;
  assign v = (a_msb_i == b_msb_i) && (sum_i[W-1] != a_msb_i);
`ifdef ALU_RESULT_SATURATE_EN
  assign result_o = v ? {a_msb_i, {(W-1){~a_msb_i}}} : sum_i;
`else
  assign result_o = sum_i;
`endif
  assign flags_o[FLAG_Z] = result_o == '0;
  assign flags_o[FLAG_N] = result_o[W-1];
  assign flags_o[FLAG_C] = carry_i;
  assign flags_o[FLAG_V] = v;
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: flag capture, 2-entry skid buffer and saturating overflow counter.
// Optional output saturation under ALU_RESULT_SATURATE_EN (see alu_flag_gen).
module alu_result_stage #(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_carry,
  input  logic             in_a_msb,
  input  logic             in_b_msb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             clr_count
);
  import alu_pkg::*;
  state_e state_q, state_d;
  logic [WIDTH-1:0] main_res_q, main_res_d, skid_res_q, skid_res_d, gen_res;
  logic [3:0] main_flg_q, main_flg_d, skid_flg_q, skid_flg_d, gen_flg;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic in_ready_q, accept, xfer;
  alu_flag_gen #(.W(WIDTH)) u_flag_gen (
    .sum_i    (in_sum),
    .carry_i  (in_carry),
    .a_msb_i  (in_a_msb),
    .b_msb_i  (in_b_msb),
    .result_o (gen_res),
    .flags_o  (gen_flg)
  );
  assign accept = in_valid && in_ready_q;
  assign xfer = out_valid && out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_res_q <= '0;
      main_flg_q <= '0;
      skid_res_q <= '0;
      skid_flg_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= state_d != FULL;
      main_res_q <= main_res_d;
      main_flg_q <= main_flg_d;
      skid_res_q <= skid_res_d;
      skid_flg_q <= skid_flg_d;
      cnt_q      <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   state_d = accept ? ONE : EMPTY;
      ONE:     state_d = (accept && !xfer) ? FULL : (!accept && xfer) ? EMPTY : ONE;
      FULL:    state_d = xfer ? ONE : FULL;
      default: state_d = EMPTY;
    endcase
  end
  // Main takes the input when it is (or is about to become) the head; skid only fills behind a stalled head.
  always_comb begin
    main_res_d = main_res_q;
    main_flg_d = main_flg_q;
    skid_res_d = skid_res_q;
    skid_flg_d = skid_flg_q;
    if (accept && (state_q == EMPTY || xfer)) begin
      main_res_d = gen_res;
      main_flg_d = gen_flg;
    end else if (state_q == FULL && xfer) begin
      main_res_d = skid_res_q;
      main_flg_d = skid_flg_q;
    end
    if (accept && state_q == ONE && !xfer) begin
      skid_res_d = gen_res;
      skid_flg_d = gen_flg;
    end
  end
  always_comb begin
    cnt_d = clr_count ? '0 : (accept && gen_flg[FLAG_V] && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_comb begin
    out_valid  = state_q != EMPTY;
    in_ready   = in_ready_q;
    out_result = main_res_q;
    out_flags  = main_flg_q;
    ovf_count  = cnt_q;
  end
endmodule
